// File: rtl/sap_pkg.sv
// Shared definitions for the SAP datapath and its microcode sequencer.
// Latency: none (constants and types only).
// Backpressure: none.
// Contents: control-word bit masks, opcode constants, bus/address widths, control-word struct.
package sap_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;

  // Control-word bit masks, MSB first: HLT MI RI RO IO II AI AO EO SU BI OI CE CO J FI
  localparam logic [15:0] CW_HLT = 16'h8000;
  localparam logic [15:0] CW_MI  = 16'h4000;
  localparam logic [15:0] CW_RI  = 16'h2000;
  localparam logic [15:0] CW_RO  = 16'h1000;
  localparam logic [15:0] CW_IO  = 16'h0800;
  localparam logic [15:0] CW_II  = 16'h0400;
  localparam logic [15:0] CW_AI  = 16'h0200;
  localparam logic [15:0] CW_AO  = 16'h0100;
  localparam logic [15:0] CW_EO  = 16'h0080;
  localparam logic [15:0] CW_SU  = 16'h0040;
  localparam logic [15:0] CW_BI  = 16'h0020;
  localparam logic [15:0] CW_OI  = 16'h0010;
  localparam logic [15:0] CW_CE  = 16'h0008;
  localparam logic [15:0] CW_CO  = 16'h0004;
  localparam logic [15:0] CW_J   = 16'h0002;
  localparam logic [15:0] CW_FI  = 16'h0001;

  // Opcodes carried in IR[7:4]
  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LDA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_STA = 4'd4;
  localparam logic [3:0] OP_LDI = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JC  = 4'd7;
  localparam logic [3:0] OP_JZ  = 4'd8;
  localparam logic [3:0] OP_OUT = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  // Field order matches the bit masks above so a plain cast decodes the word.
  typedef struct packed {
    logic hlt;
    logic mi;
    logic ri;
    logic ro;
    logic io;
    logic ii;
    logic ai;
    logic ao;
    logic eo;
    logic su;
    logic bi;
    logic oi;
    logic ce;
    logic co;
    logic j;
    logic fi;
  } ctrl_t;

endpackage

// File: rtl/sap_alu.sv
// 8-bit add/subtract unit for the SAP datapath.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_a, i_b operands; i_su selects subtract; o_result sum, o_carry carry-out
// (for subtract, 1 = no borrow), o_zero set when o_result is zero.
module sap_alu
  import sap_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic              i_su,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero
);

  logic [DATA_W-1:0] w_b_op;
  logic [DATA_W:0]   w_sum;

  // Subtract is two's complement: invert B and inject the +1 as carry-in.
  assign w_b_op   = i_su ? ~i_b : i_b;
  assign w_sum    = {1'b0, i_a} + {1'b0, w_b_op} + {{DATA_W{1'b0}}, i_su};
  assign o_result = w_sum[DATA_W-1:0];
  assign o_carry  = w_sum[DATA_W];
  assign o_zero   = (w_sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_datapath.sv
// SAP register-transfer datapath: shared 8-bit bus, PC, MAR, RAM, IR, A, B, ALU, flags, output reg.
// Latency: loads commit on the falling edge after the rising edge that presented ctrl_data.
// Backpressure: none; halt freezes all control-word driven state, prog_we still writes RAM.
// Ports: clk, rst (async active-high); ctrl_data control word; prog_we/prog_addr/prog_data
// program loader; instruction, ovf, zf back to sequencer; out_data/out_valid output register;
// halted sticky halt; bus_conflict flags multiple simultaneous bus drivers.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int RAM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ctrl_data,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        instruction,
  output logic              ovf,
  output logic              zf,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic              bus_conflict
);

  ctrl_t             w_ctrl;
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W-1:0] w_ram_rd;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_carry;
  logic              w_alu_zero;
  logic [4:0]        w_drv;
  logic              w_ram_we;

  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_mar;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_out;
  logic              r_out_valid;
  logic              r_ovf;
  logic              r_zf;
  logic              r_halted;
  logic [DATA_W-1:0] r_ram [RAM_WORDS];

  assign w_ctrl = ctrl_t'(ctrl_data);

  sap_alu u_alu (
    .i_a      (r_a),
    .i_b      (r_b),
    .i_su     (w_ctrl.su),
    .o_result (w_alu_res),
    .o_carry  (w_alu_carry),
    .o_zero   (w_alu_zero)
  );

  assign w_ram_rd = r_ram[r_mar];

  // Bus mux with fixed priority EO > AO > RO > IO > CO; idle bus reads zero.
  always_comb begin
    w_bus = '0;
    if (w_ctrl.eo)      w_bus = w_alu_res;
    else if (w_ctrl.ao) w_bus = r_a;
    else if (w_ctrl.ro) w_bus = w_ram_rd;
    else if (w_ctrl.io) w_bus = {4'h0, r_ir[3:0]};
    else if (w_ctrl.co) w_bus = {4'h0, r_pc};
  end

  // More than one bit set <=> clearing the lowest set bit leaves something.
  assign w_drv        = {w_ctrl.eo, w_ctrl.ao, w_ctrl.ro, w_ctrl.io, w_ctrl.co};
  assign bus_conflict = |(w_drv & (w_drv - 5'd1));

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= '0;
      r_mar       <= '0;
      r_ir        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_zf        <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (!r_halted) begin
        if (w_ctrl.mi) r_mar <= w_bus[ADDR_W-1:0];
        if (w_ctrl.ii) r_ir  <= w_bus;
        if (w_ctrl.ai) r_a   <= w_bus;
        if (w_ctrl.bi) r_b   <= w_bus;
        if (w_ctrl.oi) begin
          r_out       <= w_bus;
          r_out_valid <= 1'b1;
        end
        // Jump takes precedence over increment.
        if (w_ctrl.j)       r_pc <= w_bus[ADDR_W-1:0];
        else if (w_ctrl.ce) r_pc <= r_pc + 4'd1;
        if (w_ctrl.fi) begin
          r_ovf <= w_alu_carry;
          r_zf  <= w_alu_zero;
        end
        if (w_ctrl.hlt) r_halted <= 1'b1;
      end
    end
  end

  // RAM is not reset; a write from the control word is blocked while rst is high
  // so an aborted instruction leaves memory untouched. The loader port always wins.
  assign w_ram_we = w_ctrl.ri && !r_halted && !rst;

  always_ff @(negedge clk) begin
    if (prog_we)       r_ram[prog_addr] <= prog_data;
    else if (w_ram_we) r_ram[r_mar]     <= w_bus;
  end

  assign instruction = r_ir[7:4];
  assign ovf         = r_ovf;
  assign zf          = r_zf;
  assign out_data    = r_out;
  assign out_valid   = r_out_valid;
  assign halted      = r_halted;

endmodule

// File: tb/tb_sap_datapath.sv
module tb_sap_datapath;
  import sap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ctrl_data = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [7:0]  prog_data = '0;
  logic [3:0]  instruction;
  logic        ovf;
  logic        zf;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        halted;
  logic        bus_conflict;

  int n_pass = 0;
  int n_tot  = 0;

  sap_datapath #(.RAM_WORDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .ctrl_data    (ctrl_data),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .instruction  (instruction),
    .ovf          (ovf),
    .zf           (zf),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .halted       (halted),
    .bus_conflict (bus_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       su;
    logic [7:0] res;
    logic       c;
    logic       z;
  } alu_vec_t;

  alu_vec_t vecs [7];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Present one control word on a rising edge; it commits at the following falling edge.
  task automatic step(input logic [15:0] w);
    @(posedge clk);
    #1 ctrl_data = w;
    @(negedge clk);
    #2 ctrl_data = '0;
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d);
    @(posedge clk);
    #1;
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    @(negedge clk);
    #2 prog_we = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"add_carry",  8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 1'b0};
    vecs[1] = '{"sub_zero",   8'h07, 8'h07, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{"sub_borrow", 8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3] = '{"add_zeros",  8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{"add_wrap",   8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[5] = '{"sub_80_1",   8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0};
    vecs[6] = '{"add_plain",  8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};

    // Reset state while rst is held
    #2;
    chk("rst_instr",    {4'h0, instruction}, 8'h00);
    chk("rst_ovf",      {7'h0, ovf},         8'h00);
    chk("rst_zf",       {7'h0, zf},          8'h00);
    chk("rst_out",      out_data,            8'h00);
    chk("rst_outvld",   {7'h0, out_valid},   8'h00);
    chk("rst_halted",   {7'h0, halted},      8'h00);
    chk("idle_conflict",{7'h0, bus_conflict},8'h00);
    #10 rst = 1'b0;

    // ALU table: MAR stays 0, operands loaded through RAM[0]
    for (int i = 0; i < 7; i++) begin
      prog(4'h0, vecs[i].a);
      step(CW_RO | CW_AI);
      prog(4'h0, vecs[i].b);
      step(CW_RO | CW_BI);
      step(CW_EO | CW_AI | CW_FI | (vecs[i].su ? CW_SU : 16'h0));
      chk({vecs[i].name, "_ovf"}, {7'h0, ovf}, {7'h0, vecs[i].c});
      chk({vecs[i].name, "_zf"},  {7'h0, zf},  {7'h0, vecs[i].z});
      step(CW_AO | CW_OI);
      chk({vecs[i].name, "_a"}, out_data, vecs[i].res);
    end

    // Flags hold without FI
    prog(4'h0, 8'hFF); step(CW_RO | CW_AI);
    prog(4'h0, 8'h01); step(CW_RO | CW_BI);
    step(CW_EO | CW_FI);
    prog(4'h0, 8'h02); step(CW_RO | CW_AI);
    step(CW_EO | CW_AI);
    chk("hold_ovf", {7'h0, ovf}, 8'h01);
    chk("hold_zf",  {7'h0, zf},  8'h01);
    step(CW_AO | CW_OI);
    chk("nofi_a", out_data, 8'h03);

    // Fetch
    prog(4'h0, 8'h1E);
    step(CW_MI | CW_CO);
    step(CW_RO | CW_II | CW_CE);
    chk("fetch_instr", {4'h0, instruction}, 8'h01);
    step(CW_IO | CW_OI);
    chk("fetch_ir_lo", out_data, 8'h0E);
    chk("outvld_hi", {7'h0, out_valid}, 8'h01);
    step(CW_CO | CW_OI);
    chk("fetch_pc", out_data, 8'h01);
    step(16'h0);
    chk("outvld_lo", {7'h0, out_valid}, 8'h00);

    // ADD with carry via IR operand
    prog(4'h0, 8'hF0); step(CW_RO | CW_AI);
    prog(4'h0, 8'h25); step(CW_RO | CW_II);
    chk("add_instr", {4'h0, instruction}, 8'h02);
    prog(4'h5, 8'h20);
    step(CW_IO | CW_MI);
    step(CW_RO | CW_BI);
    step(CW_EO | CW_AI | CW_FI);
    chk("add_ovf", {7'h0, ovf}, 8'h01);
    chk("add_zf",  {7'h0, zf},  8'h00);
    step(CW_AO | CW_OI);
    chk("add_a", out_data, 8'h10);

    // Jump beats CE, then PC wrap
    prog(4'h5, 8'h29); step(CW_RO | CW_II);
    step(CW_IO | CW_J | CW_CE);
    step(CW_CO | CW_OI);
    chk("jump_pc", out_data, 8'h09);
    prog(4'h5, 8'h0F); step(CW_RO | CW_J);
    step(CW_CE);
    step(CW_CO | CW_OI);
    chk("wrap_pc", out_data, 8'h00);

    // STA
    prog(4'h5, 8'h5A); step(CW_RO | CW_AI);
    prog(4'h5, 8'h0C); step(CW_RO | CW_MI);
    prog(4'hC, 8'h00);
    step(CW_AO | CW_RI);
    step(CW_RO | CW_OI);
    chk("sta_ram", out_data, 8'h5A);

    // prog_we and RI on the same edge: loader wins
    @(posedge clk);
    #1;
    ctrl_data = CW_AO | CW_RI;
    prog_we = 1'b1; prog_addr = 4'hC; prog_data = 8'h33;
    @(negedge clk);
    #2; ctrl_data = '0; prog_we = 1'b0;
    step(CW_RO | CW_OI);
    chk("prog_wins", out_data, 8'h33);

    // Bus conflict and priority
    @(posedge clk);
    #1 ctrl_data = CW_CO | CW_OI;
    #1 chk("single_drv", {7'h0, bus_conflict}, 8'h00);
    @(negedge clk);
    #2 ctrl_data = '0;
    @(posedge clk);
    #1 ctrl_data = CW_AO | CW_CO | CW_OI;
    #1 chk("conflict", {7'h0, bus_conflict}, 8'h01);
    @(negedge clk);
    #2 ctrl_data = '0;
    chk("prio_ao", out_data, 8'h5A);
    step(CW_CO | CW_OI);

    // Halt
    step(CW_HLT);
    chk("halted", {7'h0, halted}, 8'h01);
    step(CW_AO | CW_OI);
    chk("halt_out", out_data, 8'h00);
    chk("halt_vld", {7'h0, out_valid}, 8'h00);
    prog(4'h0, 8'h77);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("halt_clr", {7'h0, halted}, 8'h00);
    @(negedge clk);
    #2 rst = 1'b0;
    step(CW_RO | CW_OI);
    chk("halt_progwe", out_data, 8'h77);

    // Reset mid-instruction
    prog(4'h0, 8'hC8);
    step(CW_RO | CW_AI | CW_II | CW_OI);
    chk("pre_instr", {4'h0, instruction}, 8'h0C);
    step(CW_RO | CW_BI);
    step(CW_EO | CW_FI);
    chk("pre_ovf", {7'h0, ovf}, 8'h01);
    @(posedge clk);
    #1 ctrl_data = CW_EO | CW_AI | CW_FI | CW_RI | CW_OI;
    #2 rst = 1'b1;
    #1;
    chk("mid_instr", {4'h0, instruction}, 8'h00);
    chk("mid_ovf",   {7'h0, ovf},         8'h00);
    chk("mid_out",   out_data,            8'h00);
    @(negedge clk);
    #2;
    chk("mid_vld", {7'h0, out_valid}, 8'h00);
    ctrl_data = '0;
    rst = 1'b0;
    step(CW_RO | CW_OI);
    chk("mid_ram", out_data, 8'hC8);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/sap_datapath.md
# sap_datapath

Register-transfer datapath for the 8-bit SAP microcomputer. It consumes the 16-bit control word from the microcode sequencer and drives a shared 8-bit bus. The bus connects the PC, MAR, 16×8 RAM, IR, A, B, ALU, flags and output register. It returns the opcode and the carry/zero flags to the sequencer, forming the far end of the control-word interface.

## Interface
- `RAM_WORDS`, default 16: RAM depth. The address is 4 bits wide.
- `clk` in 1: system clock. All state updates on the falling edge.
- `rst` in 1: asynchronous, active-high reset.
- `ctrl_data` in 16: control word. Bits 15..0 are HLT, MI, RI, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI.
- `prog_we` in 1: external RAM write strobe, used for program loading.
- `prog_addr` in 4: external RAM write address.
- `prog_data` in 8: external RAM write data.
- `instruction` out 4: IR[7:4], the opcode.
- `ovf` out 1: latched carry flag.
- `zf` out 1: latched zero flag.
- `out_data` out 8: output register.
- `out_valid` out 1: one-cycle pulse after the output register loads.
- `halted` out 1: sticky halt.
- `bus_conflict` out 1: asserted combinationally when more than one bus driver is active.

## Operation
- **Bus drivers:**
  - CO drives {4'h0, PC}.
  - RO drives RAM[MAR].
  - IO drives {4'h0, IR[3:0]}.
  - AO drives A.
  - EO drives the ALU result.
- **Driver priority:** with no driver active, the bus reads 8'h00. If several drivers are active, priority is EO > AO > RO > IO > CO, and `bus_conflict`=1 for that cycle.
- **ALU (combinational):**
  - r9 = {1'b0,A} + {1'b0, SU ? ~B : B} + SU.
  - The result is r9[7:0]; carry is r9[8]; zero is (r9[7:0]==0).
  - For SUB, carry=1 means "no borrow".
- **Register loads** at the falling edge while the load bit is set:
  - MI: MAR←bus[3:0].
  - II: IR←bus.
  - AI: A←bus.
  - BI: B←bus.
  - OI: out_data←bus.
  - J: PC←bus[3:0].
  - RI: RAM[MAR]←bus.
- **Program counter:** CE increments PC modulo 16, so 4'hF wraps to 4'h0. If J and CE are both set, J wins.
- **Flags:** FI latches ovf←carry and zf←zero from the current ALU result. Without FI, the flags hold.
- **Same-edge reads:** loads sample pre-edge values. For example, EO|AI|FI in one word computes from the old A, then loads A and the flags together.
- **Halt:** HLT sets `halted`. While `halted`=1, every datapath register and RAM write from `ctrl_data` is suppressed. `prog_we` still writes. Only `rst` clears `halted`.
- **External writes:** `prog_we` writes RAM[prog_addr]←prog_data at any time. If `prog_we` and RI target the same edge, `prog_we` wins and the RI write is dropped.
- **Reset:**
  - Clears PC, MAR, IR, A, B, out_data, ovf, zf, out_valid and halted to 0.
  - RAM contents are not reset.
  - Reset asserted mid-instruction aborts with no partial RAM write.

## Timing
- **Edge split:** the sequencer updates `ctrl_data` on the rising edge, and the datapath commits on the following falling edge. Outputs are therefore stable before the next rising edge, when the sequencer samples `instruction`, `ovf` and `zf`.
- **Latency:**
  - A register load is visible half a cycle after the rising edge that presented the control word.
  - RAM reads are combinational from MAR.
  - `out_valid` rises at the falling edge that loads out_data and falls at the next falling edge.
- **Flags:** `ovf`/`zf` change only on FI edges.
- **Reset response:** reset assertion acts immediately on all outputs. Deassertion takes effect at the next falling edge.

## Structure
- **Package `sap_pkg`** holds:
  - the 16 control-bit masks (HLT..FI), shared with the sequencer;
  - the opcode constants (NOP=0, LDA=1, ADD=2, SUB=3, STA=4, LDI=5, JMP=6, JC=7, JZ=8, OUT=14, HLT=15);
  - the bus-width and address-width localparams.
- **Sub-module `sap_alu`:** 8-bit add/subtract returning result, carry and zero.
- **RAM:** an inferred array inside `sap_datapath`.

## Test plan
- Fetch: preload RAM[0]=8'h1E. Apply MI|CO, then RO|II|CE. Required: IR=8'h1E, instruction=4'h1, PC=1.
- ADD with carry: A=8'hF0, RAM[5]=8'h20. Apply IO|MI with IR low nibble 5, then RO|BI, then EO|AI|FI. Required: A=8'h10, ovf=1, zf=0.
- SUB to zero: A=8'h07, B=8'h07, apply EO|AI|SU|FI. Required: A=8'h00, ovf=1, zf=1. Then with A=3, B=5: A=8'hFE, ovf=0, zf=0.
- Jump and wrap:
  - PC=4'hF with CE gives PC=0.
  - J|CE with bus=4'h9 via IO gives PC=9.
  - STA (AO|RI) with MAR=4'hC and A=8'h5A leaves RAM[12]=8'h5A.
- Halt and conflict:
  - HLT sets `halted`.
  - A subsequent AI|CO leaves A unchanged.
  - `prog_we` still writes.
  - AO|CO in one cycle gives bus=A and `bus_conflict`=1.
- Reset mid-op: assert `rst` between the RO|BI and EO|AI|FI words. Required: every output is 0 at once, RAM unchanged, and `out_valid` never pulsed.
